// File: rtl/fp_cmp_pkg.sv
// Shared single-precision field layout, flag encodings and the argmax sequencer states.
package fp_cmp_pkg;

   localparam int unsigned FP_W     = 32;
   localparam int unsigned SIGN_BIT = 31;
   localparam int unsigned EXP_MSB  = 30;
   localparam int unsigned EXP_LSB  = 23;
   localparam int unsigned MAN_MSB  = 22;

   localparam logic [FP_W-1:0] FP_TRUE  = 32'h3f80_0000;
   localparam logic [FP_W-1:0] FP_FALSE = 32'h33d6_bf95;

   typedef enum logic [1:0] {
      IDLE,
      FIRST,
      SCAN,
      DONE
   } state_t;

endpackage

// File: rtl/fp_gt.sv
// Combinational single-precision a > b by raw bit pattern (sign-magnitude order, no NaN/Inf cases).
module fp_gt
   import fp_cmp_pkg::*;
(
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   output logic            gt
);

   logic [EXP_MSB:0] mag_a;
   logic [EXP_MSB:0] mag_b;

   always_comb begin
      mag_a = {a[EXP_MSB:EXP_LSB], a[MAN_MSB:0]};
      mag_b = {b[EXP_MSB:EXP_LSB], b[MAN_MSB:0]};
      gt    = 1'b0;
      if (a == b) begin
         gt = 1'b0;
      end else if (a[SIGN_BIT] != b[SIGN_BIT]) begin
         gt = ~a[SIGN_BIT];
      end else if (!a[SIGN_BIT]) begin
         gt = (mag_a > mag_b);
      end else begin
         gt = (mag_a < mag_b);
      end
   end

endmodule

// File: rtl/fp_argmax_seq.sv
// Streaming argmax over a programmed-length run of single-precision words.
// One shared fp_gt compares each accepted word against the registered running max.
module fp_argmax_seq
   import fp_cmp_pkg::*;
#(
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned IDX_W   = $clog2(MAX_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IDX_W:0]   len,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [FP_W-1:0]  s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [FP_W-1:0]  m_max,
   output logic [IDX_W-1:0] m_idx,
   output logic             m_empty,
   output logic             busy
);

   localparam int unsigned         LEN_W     = IDX_W + 1;
   localparam logic [LEN_W-1:0]    MAX_LEN_L = LEN_W'(MAX_LEN);

   state_t           state;
   state_t           state_nxt;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] len_clamp_c;
   logic             accept_c;
   logic             last_c;
   logic             gt_c;

   // m_max doubles as the running max, so the comparator sees the registered value.
   fp_gt u_gt (
      .a  (s_data),
      .b  (m_max),
      .gt (gt_c)
   );

   assign len_clamp_c = (len > MAX_LEN_L) ? MAX_LEN_L : len;
   assign accept_c    = s_valid & s_ready;
   assign last_c      = (cnt == len_q - LEN_W'(1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = (len_clamp_c == '0) ? DONE : FIRST;
         FIRST: if (accept_c) state_nxt = last_c ? DONE : SCAN;
         SCAN:  if (accept_c && last_c) state_nxt = DONE;
         DONE:  if (m_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake flags are registered decodes of the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         s_ready <= 1'b0;
         m_valid <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         s_ready <= (state_nxt == FIRST) || (state_nxt == SCAN);
         m_valid <= (state_nxt == DONE);
         busy    <= (state_nxt != IDLE);
      end
   end

   // Running max/index and element counter; ties keep the earlier index.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q   <= '0;
         cnt     <= '0;
         m_max   <= '0;
         m_idx   <= '0;
         m_empty <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            len_q   <= len_clamp_c;
            cnt     <= '0;
            m_empty <= (len_clamp_c == '0);
            if (len_clamp_c == '0) begin
               m_max <= '0;
               m_idx <= '0;
            end
         end
         if (accept_c) begin
            cnt <= cnt + LEN_W'(1);
            if (state == FIRST) begin
               m_max <= s_data;
               m_idx <= '0;
            end else if (gt_c) begin
               m_max <= s_data;
               m_idx <= IDX_W'(cnt);
            end
         end
      end
   end

endmodule

// File: doc/fp_argmax_seq.md
# fp_argmax_seq

Streaming max-finder built around the team's single-precision greater-than datapath. After a start pulse it accepts a programmed number of IEEE-754 words over a valid/ready stream. Each word is compared against a running maximum, and the block then presents the maximum value and its index on a held result handshake. It sits between a sample buffer and downstream decision logic. One shared comparator instance is sequenced once per accepted word.

## Interface
Parameters:
- MAX_LEN, 16: largest sequence length; must be ≥ 2.
- IDX_W, $clog2(MAX_LEN): index width.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: reset, synchronous, active-high.
- start, input, 1: begin a sequence; honoured only in IDLE.
- len, input, IDX_W+1: number of words; sampled on accepted start; valid range 0..MAX_LEN.
- s_valid, input, 1: input word valid.
- s_ready, output, 1: block accepts a word.
- s_data, input, 32: IEEE-754 single word.
- m_valid, output, 1: result valid.
- m_ready, input, 1: result consumed.
- m_max, output, 32: maximum word.
- m_idx, output, IDX_W: 0-based position of the maximum.
- m_empty, output, 1: the sequence had len==0.
- busy, output, 1: state is not IDLE.

## Operation
- States and transitions:
  - IDLE: start with len==0 goes to DONE with m_empty=1. Start with len>0 goes to FIRST.
  - FIRST: on an accepted word, load the running max and set idx=0. Goes to DONE if len==1, else to SCAN.
  - SCAN: on each accepted word, replace max/idx if the word is greater than the current max. After the len-th word, go to DONE.
  - DONE: hold m_valid until m_ready. On the m_valid&m_ready cycle, go to IDLE.
- A word is accepted on s_valid&s_ready. s_ready=1 only in FIRST and SCAN.
- An element counter counts accepted words, from 0 to len-1.
- Greater-than rule, with a = candidate word and b = running max:
  - Signs differ: the positive word is greater. +0 (0x00000000) > -0 (0x80000000).
  - Both positive: compare {exp,mantissa} unsigned; larger is greater.
  - Both negative: compare {exp,mantissa} unsigned; smaller is greater.
  - Identical patterns: not greater.
  - NaN and Inf get no special handling; they compare by bit pattern under the same rule.
- Ties keep the earliest index, because replacement happens only on strict greater-than.
- m_empty=1 gives m_max=0x00000000 and m_idx=0.
- len > MAX_LEN is clamped to MAX_LEN at sampling.
- start outside IDLE is ignored, including during DONE on the same cycle as m_ready. len is not re-sampled.
- s_valid is ignored outside FIRST and SCAN. Words presented then are not consumed.

## Timing
- Reset values: state=IDLE, s_ready=0, m_valid=0, m_max=0, m_idx=0, m_empty=0, busy=0. The counter and running max are cleared.
- rst mid-sequence aborts immediately. The next cycle is IDLE with no result emitted.
- start accepted at cycle t: s_ready=1 from t+1.
- Last word accepted at cycle u: m_valid=1 from u+1.
- Minimum latency, len=N with s_valid held high: start at t, m_valid at t+N+1.
- len==0: m_valid at t+1.
- m_max, m_idx and m_empty are registered. They are stable while m_valid=1 and retain their values after the handshake until the next load.
- busy=0 in the cycle after the result handshake. A new start is accepted from that cycle.
- The comparator is combinational between s_data and the registered max. Running max and index update on the accepting edge, a single cycle per word.

## Structure
- Package fp_cmp_pkg holds:
  - Field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_MSB=22.
  - Flag constants: FP_TRUE=32'h3f800000, FP_FALSE=32'h33d6bf95, used by sibling blocks.
  - State enum: IDLE, FIRST, SCAN, DONE.
- Sub-module fp_gt: combinational, inputs a and b (32 bits each), output gt (1 bit), implementing the greater-than rule above. It is instantiated once and reused by later schedulers.

## Test plan
- len=4, words 0x3f800000, 0x40400000, 0xc0000000, 0x40000000, s_valid held high → m_max=0x40400000, m_idx=1; m_valid five cycles after start.
- len=3, words 0x80000000, 0x00000000, 0x80000000 → m_max=0x00000000, m_idx=1 (+0 beats -0). len=2, words 0x40000000, 0x40000000 → m_idx=0 (tie keeps earliest).
- All-negative len=3, words 0xc0400000, 0xbf800000, 0xc0000000 → m_max=0xbf800000, m_idx=1.
- len=0 → m_valid one cycle after start, m_empty=1, m_max=0. len=MAX_LEN+5 → exactly MAX_LEN words consumed.
- Random s_valid gaps plus m_ready held low 10 cycles → result stable; start pulses during SCAN and DONE are ignored; busy drops after the handshake.
- rst asserted after two of four words → next cycle IDLE, m_valid=0, s_ready=0. A fresh start with len=1, word 0x7f800000 → m_max=0x7f800000, m_idx=0.
